// File: rtl/clock_ui_controller_if.sv
`default_nettype none
// ============================================================================
//  Module   : clock_ui_controller_if
//  Brief    : Board-side bundle of the front-panel controller (raw buttons,
//             clock-core events in; mode/select/strobe/enables/buzzer out).
//  Revision : 1.0 - initial release
// ============================================================================
interface clock_ui_controller_if;
    logic       btn_c;
    logic       btn_u;
    logic       btn_l;
    logic       btn_r;
    logic       btn_d;
    logic       alarm_out;
    logic       timer_out;
    logic [1:0] mode;
    logic [1:0] select;
    logic       increment;
    logic       alarm_enable;
    logic       timer_enable;
    logic       aud_pwm;
    logic       ringing;

    modport master (
        input  btn_c, btn_u, btn_l, btn_r, btn_d, alarm_out, timer_out,
        output mode, select, increment, alarm_enable, timer_enable, aud_pwm, ringing
    );

    modport slave (
        output btn_c, btn_u, btn_l, btn_r, btn_d, alarm_out, timer_out,
        input  mode, select, increment, alarm_enable, timer_enable, aud_pwm, ringing
    );
endinterface
`default_nettype wire

// File: rtl/clock_ui_controller.sv
`default_nettype none
// ============================================================================
//  Module   : clock_ui_controller
//  Brief    : Debounced front-panel control and buzzer scheduling for the
//             DigitalClock core. Define CLOCK_UI_AUTO_REPEAT_EN to enable
//             increment auto-repeat while btn_u is held.
//  Revision : 1.0 - initial release
// ============================================================================
module clock_ui_controller #(
    parameter int CLK_FREQ        = 100_000_000,
    parameter int DEBOUNCE_MS     = 10,
    parameter int REPEAT_DELAY_MS = 500,
    parameter int REPEAT_RATE_MS  = 100,
    parameter int TONE_HZ         = 1500,
    parameter int RING_TIMEOUT_S  = 60
) (
    input  logic                  clk,
    input  logic                  reset,
    clock_ui_controller_if.master ui_bus
);

    localparam longint c_DEB_N   = longint'(DEBOUNCE_MS) * longint'(CLK_FREQ) / 1000;
    localparam int     c_DEB_W   = (c_DEB_N > 1) ? $clog2(c_DEB_N) : 1;
    localparam int     c_HALF    = CLK_FREQ / (2 * TONE_HZ);
    localparam int     c_TONE_W  = (c_HALF > 1) ? $clog2(c_HALF) : 1;
    localparam longint c_TOUT    = longint'(RING_TIMEOUT_S) * longint'(CLK_FREQ);
    localparam int     c_TOUT_W  = (c_TOUT > 1) ? $clog2(c_TOUT) : 1;
    localparam int     c_BTN_D   = 0;
    localparam int     c_BTN_R   = 1;
    localparam int     c_BTN_L   = 2;
    localparam int     c_BTN_U   = 3;
    localparam int     c_BTN_C   = 4;
    localparam logic [1:0] c_SEL_NONE = 2'd0;
    localparam logic [1:0] c_SEL_SEC  = 2'd1;

    typedef enum logic [1:0] {MODE_CLOCK = 2'd0, MODE_TIMER = 2'd1, MODE_ALARM = 2'd2} mode_t;
    typedef enum logic [1:0] {RING_IDLE  = 2'd0, RING_ALARM = 2'd1, RING_TIMER = 2'd2} ring_t;

    generate
        if (DEBOUNCE_MS < 1 || TONE_HZ < 1 || REPEAT_DELAY_MS < 1 || REPEAT_RATE_MS < 1 ||
            RING_TIMEOUT_S < 1) begin : g_cfg_check
            $error("clock_ui_controller: timing parameters must be positive");
        end
    endgenerate

    logic [4:0] w_btn_raw;
    logic [4:0] r_sync1;
    logic [4:0] r_sync2;
    logic [4:0] w_deb;
    logic [4:0] r_deb_q;
    logic [4:0] w_press;

    assign w_btn_raw = {ui_bus.btn_c, ui_bus.btn_u, ui_bus.btn_l, ui_bus.btn_r, ui_bus.btn_d};
    assign w_press   = w_deb & ~r_deb_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb_q <= '0;
        end else begin
            r_sync1 <= w_btn_raw;
            r_sync2 <= r_sync1;
            r_deb_q <= w_deb;
        end
    end

    // Any cycle where the synchronized level agrees with the accepted one restarts the count.
    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_btn
            logic [c_DEB_W-1:0] r_cnt;
            logic               r_deb;
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_cnt <= '0;
                    r_deb <= 1'b0;
                end else if (r_sync2[gi] != r_deb) begin
                    if (r_cnt == c_DEB_W'(c_DEB_N - 1)) begin
                        r_deb <= r_sync2[gi];
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_DEB_W'(1);
                    end
                end else begin
                    r_cnt <= '0;
                end
            end
            assign w_deb[gi] = r_deb;
        end
    endgenerate

    ring_t                r_ring, w_ring_nxt;
    mode_t                r_mode, w_mode_nxt;
    logic [1:0]           r_select, w_select_nxt;
    logic                 r_alarm_en, w_alarm_en_nxt;
    logic                 r_timer_en, w_timer_en_nxt;
    logic                 r_increment, w_inc_nxt;
    logic                 r_alarm_armed;
    logic                 r_timer_armed;
    logic [c_TONE_W-1:0]  r_tone_cnt;
    logic                 r_pwm;
    logic [c_TOUT_W-1:0]  r_ring_cnt;
    logic                 w_timeout;
    logic                 w_repeat;

    assign w_timeout = (r_ring_cnt == c_TOUT_W'(c_TOUT - 1));

`ifdef CLOCK_UI_AUTO_REPEAT_EN
    localparam longint c_REP_DLY  = longint'(REPEAT_DELAY_MS) * longint'(CLK_FREQ) / 1000;
    localparam longint c_REP_RATE = longint'(REPEAT_RATE_MS) * longint'(CLK_FREQ) / 1000;
    localparam longint c_REP_MAX  = (c_REP_DLY > c_REP_RATE) ? c_REP_DLY : c_REP_RATE;
    localparam int     c_REP_W    = $clog2(c_REP_MAX + 1);

    logic [c_REP_W-1:0] r_rep_cnt;
    logic               r_rep_fast;

    // Counter holds the hold offset since the last pulse; first gap is the delay, then the rate.
    assign w_repeat = w_deb[c_BTN_U] && (r_ring == RING_IDLE) &&
                      (r_rep_cnt == (r_rep_fast ? c_REP_W'(c_REP_RATE) : c_REP_W'(c_REP_DLY)));

    always_ff @(posedge clk) begin
        if (reset || !w_deb[c_BTN_U] || r_ring != RING_IDLE) begin
            r_rep_cnt  <= '0;
            r_rep_fast <= 1'b0;
        end else if (w_repeat) begin
            r_rep_cnt  <= c_REP_W'(1);
            r_rep_fast <= 1'b1;
        end else begin
            r_rep_cnt  <= r_rep_cnt + c_REP_W'(1);
        end
    end
`else
    assign w_repeat = 1'b0;
`endif

    always_comb begin
        w_ring_nxt     = r_ring;
        w_mode_nxt     = r_mode;
        w_select_nxt   = r_select;
        w_alarm_en_nxt = r_alarm_en;
        w_timer_en_nxt = r_timer_en;
        w_inc_nxt      = 1'b0;
        case (r_ring)
            RING_IDLE: begin
                if (ui_bus.alarm_out && r_alarm_armed) begin
                    w_ring_nxt   = RING_ALARM;
                    w_mode_nxt   = MODE_ALARM;
                    w_select_nxt = c_SEL_NONE;
                end else if (ui_bus.timer_out && r_timer_armed) begin
                    w_ring_nxt   = RING_TIMER;
                    w_mode_nxt   = MODE_TIMER;
                    w_select_nxt = c_SEL_NONE;
                end else begin
                    if (w_press[c_BTN_D]) w_select_nxt = r_select + 2'd1;
                    if (w_press[c_BTN_R]) begin
                        case (r_mode)
                            MODE_CLOCK: begin w_mode_nxt = MODE_TIMER; w_select_nxt = c_SEL_SEC;  end
                            MODE_TIMER: begin w_mode_nxt = MODE_ALARM; w_select_nxt = c_SEL_SEC;  end
                            default:    begin w_mode_nxt = MODE_CLOCK; w_select_nxt = c_SEL_NONE; end
                        endcase
                    end
                    if (w_press[c_BTN_C] && r_mode == MODE_TIMER) w_timer_en_nxt = ~r_timer_en;
                    if (w_press[c_BTN_L]) w_alarm_en_nxt = ~r_alarm_en;
                    w_inc_nxt = w_press[c_BTN_U] | w_repeat;
                end
            end
            default: begin
                if (|w_press) begin
                    w_ring_nxt = RING_IDLE;
                    if (r_ring == RING_TIMER) w_timer_en_nxt = 1'b0;
                end else if (w_timeout) begin
                    w_ring_nxt = RING_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ring      <= RING_IDLE;
            r_mode      <= MODE_CLOCK;
            r_select    <= c_SEL_NONE;
            r_alarm_en  <= 1'b0;
            r_timer_en  <= 1'b0;
            r_increment <= 1'b0;
        end else begin
            r_ring      <= w_ring_nxt;
            r_mode      <= w_mode_nxt;
            r_select    <= w_select_nxt;
            r_alarm_en  <= w_alarm_en_nxt;
            r_timer_en  <= w_timer_en_nxt;
            r_increment <= w_inc_nxt;
        end
    end

    // A source stays disarmed after its ring ends until its event line is seen low.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_alarm_armed <= 1'b1;
            r_timer_armed <= 1'b1;
        end else begin
            if (r_ring == RING_ALARM && w_ring_nxt == RING_IDLE) r_alarm_armed <= 1'b0;
            else if (!ui_bus.alarm_out)                        r_alarm_armed <= 1'b1;
            if (r_ring == RING_TIMER && w_ring_nxt == RING_IDLE) r_timer_armed <= 1'b0;
            else if (!ui_bus.timer_out)                        r_timer_armed <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || r_ring == RING_IDLE || w_ring_nxt == RING_IDLE) begin
            r_tone_cnt <= '0;
            r_pwm      <= 1'b0;
            r_ring_cnt <= '0;
        end else begin
            r_ring_cnt <= r_ring_cnt + c_TOUT_W'(1);
            if (r_tone_cnt == c_TONE_W'(c_HALF - 1)) begin
                r_tone_cnt <= '0;
                r_pwm      <= ~r_pwm;
            end else begin
                r_tone_cnt <= r_tone_cnt + c_TONE_W'(1);
            end
        end
    end

    assign ui_bus.mode         = r_mode;
    assign ui_bus.select       = r_select;
    assign ui_bus.increment    = r_increment;
    assign ui_bus.alarm_enable = r_alarm_en;
    assign ui_bus.timer_enable = r_timer_en;
    assign ui_bus.aud_pwm      = r_pwm;
    assign ui_bus.ringing      = (r_ring != RING_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_clock_ui_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clock_ui_controller
//  Brief    : Scoreboard bench: expected output events (cycle + value) are
//             queued by the stimulus and consumed by an independent monitor.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_clock_ui_controller;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    clock_ui_controller_if u_if ();

    clock_ui_controller #(
        .CLK_FREQ        (1000),
        .DEBOUNCE_MS     (4),
        .REPEAT_DELAY_MS (10),
        .REPEAT_RATE_MS  (3),
        .TONE_HZ         (125),
        .RING_TIMEOUT_S  (1)
    ) u_dut (
        .clk    (clk),
        .reset  (reset),
        .ui_bus (u_if)
    );

    typedef struct {
        int         at;
        logic [6:0] val;
    } ev_t;

    ev_t q_state[$];
    ev_t q_inc[$];
    ev_t q_pwm[$];

    int cyc      = 0;
    int n_checks = 0;
    int n_pass   = 0;
    logic       mon_en = 1'b0;
    logic [6:0] prev_sv;
    logic       prev_pwm;

    logic [1:0] em, es;
    logic       ea, et, er;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [6:0] cur_sv();
        return {u_if.mode, u_if.select, u_if.alarm_enable, u_if.timer_enable, u_if.ringing};
    endfunction

    function automatic void check_ev(string name, int got_at, int exp_at, logic [6:0] got, logic [6:0] exp);
        n_checks++;
        if (got_at == exp_at && got == exp) n_pass++;
        else $display("FAIL %s: observed cycle %0d value %b, expected cycle %0d value %b",
                      name, got_at, got, exp_at, exp);
    endfunction

    function automatic void check_val(string name, logic [6:0] got, logic [6:0] exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b", name, got, exp);
    endfunction

    function automatic void unexpected(string name, logic [6:0] got);
        n_checks++;
        $display("FAIL %s: unexpected event at cycle %0d value %b, expected none", name, cyc, got);
    endfunction

    // Monitor: every observable output event consumes the oldest queued expectation.
    always @(negedge clk) begin
        logic [6:0] sv;
        ev_t        e;
        if (mon_en) begin
            sv = cur_sv();
            if (sv != prev_sv) begin
                if (q_state.size() == 0) unexpected("state", sv);
                else begin e = q_state.pop_front(); check_ev("state", cyc, e.at, sv, e.val); end
            end
            prev_sv = sv;
            if (u_if.increment) begin
                if (q_inc.size() == 0) unexpected("increment", 7'd1);
                else begin e = q_inc.pop_front(); check_ev("increment", cyc, e.at, 7'd1, e.val); end
            end
            if (u_if.aud_pwm != prev_pwm) begin
                if (q_pwm.size() == 0) unexpected("aud_pwm", {6'd0, u_if.aud_pwm});
                else begin e = q_pwm.pop_front(); check_ev("aud_pwm", cyc, e.at, {6'd0, u_if.aud_pwm}, e.val); end
            end
            prev_pwm = u_if.aud_pwm;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_state(input int at);
        ev_t e;
        e.at = at; e.val = {em, es, ea, et, er};
        q_state.push_back(e);
    endtask

    task automatic push_inc(input int at);
        ev_t e;
        e.at = at; e.val = 7'd1;
        q_inc.push_back(e);
    endtask

    task automatic push_pwm(input int at, input logic v);
        ev_t e;
        e.at = at; e.val = {6'd0, v};
        q_pwm.push_back(e);
    endtask

    // mask bits: {c, u, l, r, d}
    task automatic press(input logic [4:0] mask, input int hold, input int tail);
        {u_if.btn_c, u_if.btn_u, u_if.btn_l, u_if.btn_r, u_if.btn_d} = mask;
        tick(hold);
        {u_if.btn_c, u_if.btn_u, u_if.btn_l, u_if.btn_r, u_if.btn_d} = 5'b0;
        tick(tail);
    endtask

    localparam logic [4:0] B_C = 5'b10000;
    localparam logic [4:0] B_U = 5'b01000;
    localparam logic [4:0] B_L = 5'b00100;
    localparam logic [4:0] B_R = 5'b00010;
    localparam logic [4:0] B_D = 5'b00001;

    initial begin
        int t;
        {u_if.btn_c, u_if.btn_u, u_if.btn_l, u_if.btn_r, u_if.btn_d} = 5'b0;
        u_if.alarm_out = 1'b0;
        u_if.timer_out = 1'b0;
        {em, es, ea, et, er} = 7'd0;
        reset = 1'b1;
        tick(4);
        reset = 1'b0;
        tick(1);
        check_val("reset_state", cur_sv(), 7'd0);
        check_val("reset_pwm_inc", {5'd0, u_if.aud_pwm, u_if.increment}, 7'd0);
        prev_sv  = 7'd0;
        prev_pwm = 1'b0;
        mon_en   = 1'b1;

        // Bouncy btn_u: high 2, low 1, high 8 -> one pulse 7 cycles after final rise
        t = cyc;
        push_inc(t + 10);
        u_if.btn_u = 1'b1; tick(2);
        u_if.btn_u = 1'b0; tick(1);
        u_if.btn_u = 1'b1; tick(8);
        u_if.btn_u = 1'b0; tick(12);

        // Mode cycle and timer_enable gating
        em = 2'd1; es = 2'd1; push_state(cyc + 7); press(B_R, 8, 12);
        em = 2'd2; es = 2'd1; push_state(cyc + 7); press(B_R, 8, 12);
        em = 2'd0; es = 2'd0; push_state(cyc + 7); press(B_R, 8, 12);
        press(B_C, 8, 12);
        check_val("timer_en_mode0", {6'd0, u_if.timer_enable}, 7'd0);
        em = 2'd1; es = 2'd1; push_state(cyc + 7); press(B_R, 8, 12);
        et = 1'b1;            push_state(cyc + 7); press(B_C, 8, 12);
        em = 2'd2; es = 2'd1; push_state(cyc + 7); press(B_R, 8, 12);
        em = 2'd0; es = 2'd0; push_state(cyc + 7); press(B_R, 8, 12);
        es = 2'd1;            push_state(cyc + 7); press(B_D, 8, 12);
        es = 2'd2;            push_state(cyc + 7); press(B_D, 8, 12);

        // Alarm ring from CLOCK/MIN, acknowledged with btn_l
        t = cyc;
        u_if.alarm_out = 1'b1;
        em = 2'd2; es = 2'd0; er = 1'b1; push_state(t + 1);
        for (int k = 1; k <= 5; k++) push_pwm(t + 1 + 4 * k, k[0]);
        tick(16);
        er = 1'b0; push_state(t + 23); push_pwm(t + 23, 1'b0);
        press(B_L, 8, 12);
        tick(20);
        u_if.alarm_out = 1'b0;
        tick(3);

        // Re-armed alarm left ringing until the timeout
        t = cyc;
        u_if.alarm_out = 1'b1;
        er = 1'b1; push_state(t + 1);
        for (int k = 1; k <= 250; k++) push_pwm(t + 1 + 4 * k, k[0]);
        er = 1'b0; push_state(t + 1001);
        tick(1010);
        u_if.alarm_out = 1'b0;
        tick(3);

        // Alarm and timer together: alarm first, then timer, timer ack clears timer_enable
        t = cyc;
        u_if.alarm_out = 1'b1;
        u_if.timer_out = 1'b1;
        er = 1'b1; push_state(t + 1);
        push_pwm(t + 5, 1'b1);
        tick(1);
        er = 1'b0; push_state(t + 8); push_pwm(t + 8, 1'b0);
        em = 2'd1; er = 1'b1; push_state(t + 9);
        press(B_C, 6, 1);
        push_pwm(t + 13, 1'b1);
        et = 1'b0; er = 1'b0; push_state(t + 15); push_pwm(t + 15, 1'b0);
        press(B_U, 8, 12);
        u_if.alarm_out = 1'b0;
        u_if.timer_out = 1'b0;
        tick(3);

        // alarm_enable toggle, then r+d together: r's select wins
        ea = 1'b1;            push_state(cyc + 7); press(B_L, 8, 12);
        es = 2'd1;            push_state(cyc + 7); press(B_D, 8, 12);
        em = 2'd2; es = 2'd1; push_state(cyc + 7); press(B_R | B_D, 8, 12);

        // Long btn_u hold
        t = cyc;
        push_inc(t + 7);
`ifdef CLOCK_UI_AUTO_REPEAT_EN
        push_inc(t + 17);
        push_inc(t + 20);
        push_inc(t + 23);
        push_inc(t + 26);
`endif
        press(B_U, 20, 14);

        // Reset asserted mid-ring
        t = cyc;
        u_if.alarm_out = 1'b1;
        es = 2'd0; er = 1'b1; push_state(t + 1);
        tick(3);
        reset = 1'b1;
        u_if.alarm_out = 1'b0;
        {em, es, ea, et, er} = 7'd0; push_state(t + 4);
        tick(2);
        reset = 1'b0;
        tick(20);

        while (q_state.size() > 0) begin
            ev_t e = q_state.pop_front();
            n_checks++;
            $display("FAIL state_missing: expected cycle %0d value %b, observed none", e.at, e.val);
        end
        while (q_inc.size() > 0) begin
            ev_t e = q_inc.pop_front();
            n_checks++;
            $display("FAIL increment_missing: expected cycle %0d, observed none", e.at);
        end
        while (q_pwm.size() > 0) begin
            ev_t e = q_pwm.pop_front();
            n_checks++;
            $display("FAIL aud_pwm_missing: expected cycle %0d value %b, observed none", e.at, e.val);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        wait (cyc > 20000);
        $display("FAIL watchdog: cycle %0d reached, expected completion before 20000", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
